// File: rtl/mc_control_fsm_if.sv
// Bus between the multi-cycle control FSM and the datapath it steers.
// The controller side (master) reads instruction fields and status flags
// and drives the datapath strobes, selects and debug/status pulses.
interface mc_control_fsm_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
    logic       illegal_op;
    logic       instr_done;
    logic [3:0] state;

    modport master (
        input  op, funct3, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
        output illegal_op, instr_done, state
    );

    modport slave (
        output op, funct3, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
        input  illegal_op, instr_done, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RISC-V style control unit. One state register walks each
// instruction through fetch, decode and its execution phases; all datapath
// controls are decoded combinationally from the current state and inputs.
module mc_control_fsm (
    input  logic             clk,
    input  logic             reset,
    mc_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_JALR_ADR = 4'd11,
        S_JALR_JMP = 4'd12,
        S_AUIPC    = 4'd13,
        S_LUI      = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t     r_state;
    state_t     w_next;
    logic       w_pcWrite;
    logic       w_adrSrc;
    logic       w_memWrite;
    logic       w_irWrite;
    logic       w_regWrite;
    logic [1:0] w_resultSrc;
    logic [1:0] w_aluSrcA;
    logic [1:0] w_aluSrcB;
    logic [1:0] w_aluOp;
    logic [2:0] w_immSrc;
    logic       w_illegal;
    logic       w_done;

    // State register; reset pulls the machine back to fetch without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state control decode; anything not set stays 0.
    always_comb begin
        w_next      = S_FETCH;
        w_pcWrite   = 1'b0;
        w_adrSrc    = 1'b0;
        w_memWrite  = 1'b0;
        w_irWrite   = 1'b0;
        w_regWrite  = 1'b0;
        w_resultSrc = 2'b00;
        w_aluSrcA   = 2'b00;
        w_aluSrcB   = 2'b00;
        w_aluOp     = 2'b00;
        w_illegal   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_aluSrcB   = 2'b10;
                w_resultSrc = 2'b10;
                w_irWrite   = bus.mem_ready;
                w_pcWrite   = bus.mem_ready;
                w_next      = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_aluSrcA = 2'b01;
                w_aluSrcB = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR_ADR;
                    OP_AUIPC:          w_next = S_AUIPC;
                    OP_LUI:            w_next = S_LUI;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_aluSrcA = 2'b10;
                w_aluSrcB = 2'b01;
                w_next    = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adrSrc = 1'b1;
                w_next   = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_resultSrc = 2'b01;
                w_regWrite  = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adrSrc   = 1'b1;
                w_memWrite = 1'b1;
                w_done     = bus.mem_ready;
                w_next     = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                w_aluSrcA = 2'b10;
                w_aluOp   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                w_aluSrcA = 2'b10;
                w_aluSrcB = 2'b01;
                w_aluOp   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regWrite = 1'b1;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                w_aluSrcA = 2'b01;
                w_aluSrcB = 2'b10;
                w_pcWrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_BRANCH: begin
                w_aluSrcA = 2'b10;
                w_aluOp   = 2'b01;
                w_pcWrite = bus.Zero ^ bus.funct3[0];
                w_done    = 1'b1;
                w_next    = S_FETCH;
            end
            S_JALR_ADR: begin
                w_aluSrcA = 2'b10;
                w_aluSrcB = 2'b01;
                w_next    = S_JALR_JMP;
            end
            S_JALR_JMP: begin
                w_aluSrcA = 2'b01;
                w_aluSrcB = 2'b10;
                w_pcWrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_AUIPC: begin
                w_aluSrcA = 2'b01;
                w_aluSrcB = 2'b01;
                w_next    = S_ALUWB;
            end
            S_LUI: begin
                w_aluSrcA = 2'b11;
                w_aluSrcB = 2'b01;
                w_next    = S_ALUWB;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Immediate format depends only on the opcode, whatever the state.
    always_comb begin
        w_immSrc = 3'b000;
        case (bus.op)
            OP_STORE:         w_immSrc = 3'b001;
            OP_BRANCH:        w_immSrc = 3'b010;
            OP_JAL:           w_immSrc = 3'b011;
            OP_LUI, OP_AUIPC: w_immSrc = 3'b100;
            default:          w_immSrc = 3'b000;
        endcase
    end

    assign bus.PCWrite    = w_pcWrite;
    assign bus.AdrSrc     = w_adrSrc;
    assign bus.MemWrite   = w_memWrite;
    assign bus.IRWrite    = w_irWrite;
    assign bus.RegWrite   = w_regWrite;
    assign bus.ResultSrc  = w_resultSrc;
    assign bus.ALUSrcA    = w_aluSrcA;
    assign bus.ALUSrcB    = w_aluSrcB;
    assign bus.ALUOp      = w_aluOp;
    assign bus.ImmSrc     = w_immSrc;
    assign bus.illegal_op = w_illegal;
    assign bus.instr_done = w_done;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: directed and randomized instructions, each
// expanded into its expected per-cycle trace of states and controls.
module tb_mc_control_fsm;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mc_control_fsm_if bus ();

    mc_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Immediate format each opcode needs.
    function automatic logic [2:0] immFor(input logic [6:0] op);
        if (op == OP_STORE) return 3'b001;
        if (op == OP_BRANCH) return 3'b010;
        if (op == OP_JAL) return 3'b011;
        if (op == OP_LUI || op == OP_AUIPC) return 3'b100;
        return 3'b000;
    endfunction

    // Control table: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}.
    function automatic logic [12:0] ctlFor(input int st, input logic mr, input logic z, input logic [2:0] f3);
        logic pc, adr, mw, ir, rw;
        logic [1:0] res, a, b, alu;
        pc = 0; adr = 0; mw = 0; ir = 0; rw = 0;
        res = 2'b00; a = 2'b00; b = 2'b00; alu = 2'b00;
        case (st)
            0:  begin b = 2'b10; res = 2'b10; ir = mr; pc = mr; end
            1:  begin a = 2'b01; b = 2'b01; end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  adr = 1;
            4:  begin res = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin a = 2'b10; alu = 2'b10; end
            7:  rw = 1;
            8:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
            9:  begin a = 2'b01; b = 2'b10; pc = 1; end
            10: begin a = 2'b10; alu = 2'b01; pc = z ^ f3[0]; end
            11: begin a = 2'b10; b = 2'b01; end
            12: begin a = 2'b01; b = 2'b10; pc = 1; end
            13: begin a = 2'b01; b = 2'b01; end
            14: begin a = 2'b11; b = 2'b01; end
            default: ;
        endcase
        return {pc, adr, mw, ir, rw, res, a, b, alu};
    endfunction

    // Compares every DUT output with the expectation for one cycle.
    task automatic checkOutput(input string tag, input int st, input logic ill, input logic done);
        logic [21:0] obs;
        logic [21:0] expv;
        obs = {bus.state, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
               bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc,
               bus.illegal_op, bus.instr_done};
        expv = {st[3:0], ctlFor(st, bus.mem_ready, bus.Zero, bus.funct3), immFor(bus.op), ill, done};
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s op=%b st=%0d observed=%h expected=%h", tag, bus.op, st, obs, expv);
        end
        checks++;
        assert ((bus.MemWrite & bus.RegWrite) === 1'b0) else begin
            failures++;
            $error("FAIL %s_wrexcl observed MemWrite=%b RegWrite=%b expected not both 1",
                   tag, bus.MemWrite, bus.RegWrite);
        end
    endtask

    // One clock: drive mem_ready, check mid-cycle, land just after the next edge.
    task automatic stepCycle(input string tag, input int st, input logic mr, input logic ill, input logic done);
        bus.mem_ready = mr;
        @(negedge clk);
        checkOutput(tag, st, ill, done);
        @(posedge clk);
        #1;
    endtask

    // Expands one instruction into its expected state trace and walks it.
    task automatic applyStimulus(input string tag, input logic [6:0] op, input logic [2:0] f3,
                                 input logic z, input int fStall, input int mStall);
        int   seq[$];
        logic mrq[$];
        logic legal;
        bus.op = op;
        bus.funct3 = f3;
        bus.Zero = z;
        legal = 1;
        for (int k = 0; k < fStall; k++) begin seq.push_back(0); mrq.push_back(0); end
        seq.push_back(0); mrq.push_back(1);
        seq.push_back(1); mrq.push_back(1'($urandom_range(0, 1)));
        case (op)
            OP_LOAD: begin
                seq.push_back(2); mrq.push_back(1'($urandom_range(0, 1)));
                for (int k = 0; k < mStall; k++) begin seq.push_back(3); mrq.push_back(0); end
                seq.push_back(3); mrq.push_back(1);
                seq.push_back(4); mrq.push_back(1'($urandom_range(0, 1)));
            end
            OP_STORE: begin
                seq.push_back(2); mrq.push_back(1'($urandom_range(0, 1)));
                for (int k = 0; k < mStall; k++) begin seq.push_back(5); mrq.push_back(0); end
                seq.push_back(5); mrq.push_back(1);
            end
            OP_RTYPE:  begin seq.push_back(6);  seq.push_back(7); end
            OP_ITYPE:  begin seq.push_back(8);  seq.push_back(7); end
            OP_BRANCH: seq.push_back(10);
            OP_JAL:    begin seq.push_back(9);  seq.push_back(7); end
            OP_JALR:   begin seq.push_back(11); seq.push_back(12); seq.push_back(7); end
            OP_AUIPC:  begin seq.push_back(13); seq.push_back(7); end
            OP_LUI:    begin seq.push_back(14); seq.push_back(7); end
            default:   legal = 0;
        endcase
        while (mrq.size() < seq.size()) mrq.push_back(1'($urandom_range(0, 1)));
        for (int k = 0; k < seq.size(); k++) begin
            logic last;
            last = (k == seq.size() - 1);
            stepCycle(tag, seq[k], mrq[k], last && !legal, last && legal);
        end
    endtask

    logic [6:0] legalOps [9];

    initial begin
        logic [6:0] op;
        checks = 0;
        failures = 0;
        legalOps = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI};
        reset = 1'b1;
        bus.op = OP_LOAD;
        bus.funct3 = 3'b000;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset state, with IRWrite/PCWrite following mem_ready.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_mr0", 0, 0, 0);
        bus.mem_ready = 1'b1;
        #1;
        checkOutput("reset_mr1", 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed instructions.
        applyStimulus("lw", OP_LOAD, 3'b010, 0, 0, 0);
        applyStimulus("sw_stall3", OP_STORE, 3'b010, 0, 0, 3);
        applyStimulus("beq_z1", OP_BRANCH, 3'b000, 1, 0, 0);
        applyStimulus("bne_z1", OP_BRANCH, 3'b001, 1, 0, 0);
        applyStimulus("jalr", OP_JALR, 3'b000, 0, 1, 0);
        applyStimulus("illegal_7f", 7'b1111111, 3'b000, 0, 0, 0);
        applyStimulus("lw_stall", OP_LOAD, 3'b010, 0, 2, 2);
        applyStimulus("lui", OP_LUI, 3'b000, 0, 0, 0);

        // Randomized instruction stream, roughly one in ten illegal.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 7'($urandom);
                while (op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
                                  OP_JAL, OP_JALR, OP_AUIPC, OP_LUI}) op = 7'($urandom);
            end else begin
                op = legalOps[$urandom_range(0, 8)];
            end
            applyStimulus("rand", op, 3'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the middle of a MEMREAD cycle.
        bus.op = OP_LOAD;
        bus.funct3 = 3'b010;
        stepCycle("rstrd_pre", 0, 1, 0, 0);
        stepCycle("rstrd_pre", 1, 1, 0, 0);
        stepCycle("rstrd_pre", 2, 1, 0, 0);
        bus.mem_ready = 1'b0;
        #2;
        checkOutput("rstrd_memread", 3, 0, 0);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rstrd_async", 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        stepCycle("rstrd_stall", 0, 0, 0, 0);
        stepCycle("rstrd_stall", 0, 0, 0, 0);
        applyStimulus("rstrd_resume", OP_LOAD, 3'b010, 0, 0, 0);

        // Asynchronous reset during MEMWRITE drops MemWrite at once.
        bus.op = OP_STORE;
        stepCycle("rstwr_pre", 0, 1, 0, 0);
        stepCycle("rstwr_pre", 1, 1, 0, 0);
        stepCycle("rstwr_pre", 2, 1, 0, 0);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("rstwr_memwrite", 5, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rstwr_async", 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus("rstwr_resume", OP_RTYPE, 3'b000, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
